// File: rtl/trigger_capture_pkg.sv
// Shared constants for the ADC trigger capture block.
// TRIG_TIMESTAMP_EN adds a 16-bit trigger timestamp to the packet header.
package trigger_capture_pkg;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] FILL    = 3'd1;
   localparam logic [2:0] ARMED   = 3'd2;
   localparam logic [2:0] CAPTURE = 3'd3;
   localparam logic [2:0] SEND    = 3'd4;

   localparam logic [7:0] HDR_BYTE = 8'hA5;
   localparam int         TS_W     = 16;

`ifdef TRIG_TIMESTAMP_EN
   localparam int HDR_LEN = 1 + TS_W / 8;
`else
   localparam int HDR_LEN = 1;
`endif

   function automatic int pkt_len(input int data_w, input int pre, input int post);
      return HDR_LEN + ((data_w + 7) / 8) * (pre + post);
   endfunction

endpackage

// File: rtl/trigger_capture_ram.sv
// Simple dual-port sample buffer, registered read (maps to block RAM).
// Part of trigger_capture; no build options.
module capture_ram
   import trigger_capture_pkg::*;
#(
   parameter int DATA_W = 14,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/trigger_capture.sv
// Circular ADC history, frozen on trigger and streamed as a byte packet.
// Define TRIG_TIMESTAMP_EN to insert a 16-bit trigger timestamp after the header.
module trigger_capture
   import trigger_capture_pkg::*;
#(
   parameter int DATA_W       = 14,
   parameter int PRE_SAMPLES  = 16,
   parameter int POST_SAMPLES = 48,
   parameter int ADDR_W       = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] adc_in,
   input  logic              trigger_in,
   input  logic              arm,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              trig_missed
);

   localparam int CNT_W = ADDR_W + 2;
   localparam logic [CNT_W-1:0] PKT_N = CNT_W'(pkt_len(DATA_W, PRE_SAMPLES, POST_SAMPLES));
   localparam logic [CNT_W-1:0] HDR_N = CNT_W'(HDR_LEN);
   localparam logic HDR_ODD = HDR_N[0];
   localparam logic [ADDR_W:0] PRE_LAST  = (ADDR_W+1)'(PRE_SAMPLES - 1);
   localparam logic [ADDR_W:0] POST_LAST = (ADDR_W+1)'(POST_SAMPLES - 1);

   logic [2:0]        state;
   logic [DATA_W-1:0] adc_d;
   logic [DATA_W-1:0] rd_q;
   logic [7:0]        s_lo;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   fill_cnt;
   logic [ADDR_W:0]   post_cnt;
   logic [CNT_W-1:0]  ld_cnt;
   logic              we;
   logic              load;
   logic              lo_sel;
   logic [7:0]        nxt_byte;

`ifdef TRIG_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;
   logic [TS_W-1:0] ts_lat;
`endif

   assign busy = (state != IDLE);
   assign we   = (state == FILL) || (state == ARMED) || (state == CAPTURE);
   assign load = (state == SEND) && (ld_cnt != PKT_N) && (!tx_valid || tx_ready);

   capture_ram #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk    (clk),
      .we     (we),
      .wr_addr(wr_ptr),
      .wr_data(adc_d),
      .rd_addr(rd_ptr),
      .rd_data(rd_q)
   );

   // hi byte comes straight from the RAM; lo byte from the copy taken then
   always_comb begin
      lo_sel   = ld_cnt[0] ^ HDR_ODD;
      nxt_byte = HDR_BYTE;
      if (ld_cnt >= HDR_N) nxt_byte = lo_sel ? s_lo : 8'(rd_q >> 8);
`ifdef TRIG_TIMESTAMP_EN
      else if (ld_cnt == CNT_W'(1)) nxt_byte = ts_lat[15:8];
      else if (ld_cnt == CNT_W'(2)) nxt_byte = ts_lat[7:0];
`endif
   end

`ifdef TRIG_TIMESTAMP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_cnt <= '0;
         ts_lat <= '0;
      end else begin
         ts_cnt <= ts_cnt + 1'b1;
         if (state == ARMED && trigger_in) ts_lat <= ts_cnt;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         adc_d       <= '0;
         s_lo        <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill_cnt    <= '0;
         post_cnt    <= '0;
         ld_cnt      <= '0;
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         trig_missed <= 1'b0;
      end else begin
         adc_d       <= adc_in;
         trig_missed <= trigger_in && (state != ARMED);
         case (state)
            IDLE: begin
               if (arm) begin
                  state    <= FILL;
                  wr_ptr   <= '0;
                  fill_cnt <= '0;
               end
            end
            FILL: begin
               wr_ptr   <= wr_ptr + 1'b1;
               fill_cnt <= fill_cnt + 1'b1;
               if (fill_cnt == PRE_LAST) state <= ARMED;
            end
            ARMED: begin
               wr_ptr <= wr_ptr + 1'b1;
               if (trigger_in) begin
                  // oldest pre-trigger sample sits PRE_SAMPLES behind the trigger slot
                  rd_ptr   <= wr_ptr - ADDR_W'(PRE_SAMPLES);
                  post_cnt <= (ADDR_W+1)'(1);
                  state    <= CAPTURE;
               end
            end
            CAPTURE: begin
               wr_ptr   <= wr_ptr + 1'b1;
               post_cnt <= post_cnt + 1'b1;
               if (post_cnt == POST_LAST) begin
                  state  <= SEND;
                  ld_cnt <= '0;
               end
            end
            SEND: begin
               if (load) begin
                  tx_data  <= nxt_byte;
                  tx_valid <= 1'b1;
                  ld_cnt   <= ld_cnt + 1'b1;
                  if (ld_cnt >= HDR_N && !lo_sel) begin
                     s_lo   <= rd_q[7:0];
                     rd_ptr <= rd_ptr + 1'b1;
                  end
               end else if (tx_valid && tx_ready) begin
                  tx_valid <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: window content, backpressure, early
// triggers, wrap-around, reset mid-packet and (TRIG_TIMESTAMP_EN) timestamp.
module tb_trigger_capture;
   import trigger_capture_pkg::*;

   localparam int N_BYTES = pkt_len(14, 16, 48);

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] adc_in;
   logic        trigger_in;
   logic        arm;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        trig_missed;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   bit          bp = 1'b0;
   bit          pend = 1'b0;
   logic [7:0]  held;
   logic [7:0]  rxq[$];
   logic [15:0] tcnt;

   trigger_capture dut (
      .clk        (clk),
      .reset      (reset),
      .adc_in     (adc_in),
      .trigger_in (trigger_in),
      .arm        (arm),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .trig_missed(trig_missed)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) tcnt <= '0;
      else tcnt <= tcnt + 16'd1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // observe at negedge, drive just after posedge
   task automatic step();
      @(negedge clk);
      if (reset) pend = 1'b0;
      else begin
         if (pend) begin
            chk("stall_valid", int'(tx_valid), 1);
            chk("stall_data", int'(tx_data), int'(held));
         end
         if (tx_valid && tx_ready) rxq.push_back(tx_data);
         pend = tx_valid && !tx_ready;
         held = tx_data;
      end
      @(posedge clk);
      #1;
      cyc++;
      adc_in = adc_in + 14'd1;
      tx_ready = bp ? (cyc % 3 == 0) : 1'b1;
   endtask

   task automatic capture(input string tag, input logic [13:0] t);
      logic [7:0]  exp[$];
      logic [13:0] s;
      int          guard;
      guard = 0;
      while (adc_in != t + 14'd1 && guard < 20000) begin
         step();
         guard++;
      end
      chk({tag, "_reach"}, int'(adc_in), int'(t + 14'd1));
      rxq.delete();
      exp.push_back(8'hA5);
`ifdef TRIG_TIMESTAMP_EN
      exp.push_back(tcnt[15:8]);
      exp.push_back(tcnt[7:0]);
`endif
      for (int k = 0; k < 64; k++) begin
         s = t - 14'd16 + 14'(k);
         exp.push_back({2'b00, s[13:8]});
         exp.push_back(s[7:0]);
      end
      trigger_in = 1'b1;
      step();
      trigger_in = 1'b0;
      guard = 0;
      while (rxq.size() < N_BYTES && guard < 2000) begin
         step();
         guard++;
      end
      repeat (3) step();
      chk({tag, "_len"}, rxq.size(), exp.size());
      chk({tag, "_end_valid"}, int'(tx_valid), 0);
      for (int i = 0; i < exp.size() && i < rxq.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), int'(rxq[i]), int'(exp[i]));
   endtask

   initial begin
      logic [13:0] t;
      int          guard;
      reset = 1'b1;
      adc_in = '0;
      trigger_in = 1'b0;
      arm = 1'b0;
      tx_ready = 1'b1;
      repeat (3) step();
      chk("rst_valid", int'(tx_valid), 0);
      chk("rst_data", int'(tx_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_missed", int'(trig_missed), 0);

      reset = 1'b0;
      adc_in = '0;
      arm = 1'b1;
      step();
      chk("busy_fill", int'(busy), 1);

      capture("t1", 14'd100);

      bp = 1'b1;
      capture("t2", adc_in + 14'd40);
      bp = 1'b0;

      // trigger while filling
      reset = 1'b1;
      arm = 1'b0;
      step();
      reset = 1'b0;
      step();
      chk("t3_idle", int'(busy), 0);
      arm = 1'b1;
      repeat (5) step();
      trigger_in = 1'b1;
      step();
      trigger_in = 1'b0;
      chk("t3_missed", int'(trig_missed), 1);
      step();
      chk("t3_pulse", int'(trig_missed), 0);
      rxq.delete();
      repeat (80) step();
      chk("t3_nopkt", rxq.size(), 0);
      capture("t3", adc_in + 14'd10);

      // trigger on the same edge that ends the fill
      reset = 1'b1;
      arm = 1'b0;
      step();
      reset = 1'b0;
      arm = 1'b1;
      repeat (16) step();
      trigger_in = 1'b1;
      step();
      trigger_in = 1'b0;
      chk("t3b_missed", int'(trig_missed), 1);
      rxq.delete();
      repeat (80) step();
      chk("t3b_nopkt", rxq.size(), 0);

      capture("t4", adc_in + 14'd200);

      // reset part-way through a packet
      t = adc_in + 14'd20;
      guard = 0;
      while (adc_in != t + 14'd1 && guard < 1000) begin
         step();
         guard++;
      end
      rxq.delete();
      trigger_in = 1'b1;
      step();
      trigger_in = 1'b0;
      guard = 0;
      while (rxq.size() < 40 && guard < 1000) begin
         step();
         guard++;
      end
      chk("t5_reach40", int'(rxq.size() >= 40), 1);
      reset = 1'b1;
      #1;
      chk("t5_valid", int'(tx_valid), 0);
      chk("t5_busy", int'(busy), 0);
      step();
      step();
      reset = 1'b0;
      capture("t5", adc_in + 14'd30);

`ifdef TRIG_TIMESTAMP_EN
      guard = 0;
      while (tcnt != 16'h1234 && guard < 10000) begin
         step();
         guard++;
      end
      capture("t6", adc_in - 14'd1);
      if (rxq.size() >= 3)
         chk("t6_ts", int'({rxq[1], rxq[2]}), 16'h1234);
      else
         chk("t6_short", rxq.size(), N_BYTES);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
